vend_event_arbiter: RTL and testbench

VEND_EVENT_ARBITER -- requirements
Module: vend_event_arbiter

---
 rtl/vend_event_arbiter.sv | 265 ++++++++++++++++++++++++++
 tb/tb_vend_event_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_event_arbiter.sv
// vend_event_arbiter
//   Turns five raw vending-machine buttons into a queue of single-shot events.
//   Each button is synchronized, debounced on the tick strobe, and its 0->1
//   debounced transition raises a pending bit. One pending bit is serviced per
//   clock by fixed priority (clear > purchase > quarter > dime > nickel) and
//   pushed into a small FIFO; clear flushes the FIFO and leaves itself as the
//   only entry.
//
// Ports
//   clk          system clock, all state on the rising edge
//   clr_n        asynchronous active-low reset
//   tick         one-clk-wide sample strobe for the debouncers
//   btn_clr, btn_purchase, btn_nickel, btn_dime, btn_quarter
//                raw asynchronous active-high buttons
//   ack          consumer accepts the head event
//   ev_valid     queue non-empty (registered)
//   ev_code      head event: 0 none, 1 nickel, 2 dime, 3 quarter, 4 purchase,
//                5 clear (registered, 0 when ev_valid is 0)
//   fifo_count   number of queued entries
//   overflow     sticky, an event was dropped on a full queue
module vend_event_arbiter #(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          clr_n,
  input  logic                          tick,
  input  logic                          btn_clr,
  input  logic                          btn_purchase,
  input  logic                          btn_nickel,
  input  logic                          btn_dime,
  input  logic                          btn_quarter,
  input  logic                          ack,
  output logic                          ev_valid,
  output logic [2:0]                    ev_code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned NB = 5;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);

  // Button bit positions; code of button i is i+1.
  localparam int unsigned B_NICKEL   = 0;
  localparam int unsigned B_DIME     = 1;
  localparam int unsigned B_QUARTER  = 2;
  localparam int unsigned B_PURCHASE = 3;
  localparam int unsigned B_CLEAR    = 4;

  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_NICKEL   = 3'd1,
    EV_DIME     = 3'd2,
    EV_QUARTER  = 3'd3,
    EV_PURCHASE = 3'd4,
    EV_CLEAR    = 3'd5
  } ev_code_e;

  logic [NB-1:0] btn_raw;
  assign btn_raw = {btn_clr, btn_purchase, btn_quarter, btn_dime, btn_nickel};

  // ------------------------------------------------------------------
  // Synchronizers and debouncers
  // ------------------------------------------------------------------
  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] deb_q, deb_d;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic [NB-1:0] rise;

  always_comb begin
    deb_d = deb_q;
    rise  = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
            rise[i]  = sync2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int unsigned i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Pending bits and priority service
  // ------------------------------------------------------------------
  logic [NB-1:0] pend_q, pend_d;
  logic [NB-1:0] svc_mask;
  logic          svc_clear;
  logic          svc_push;
  ev_code_e      svc_code;

  always_comb begin
    svc_mask  = '0;
    svc_code  = EV_NONE;
    svc_clear = pend_q[B_CLEAR];
    svc_push  = 1'b0;
    if (pend_q[B_CLEAR]) begin
      svc_mask[B_CLEAR] = 1'b1;
      svc_code          = EV_CLEAR;
    end else if (pend_q[B_PURCHASE]) begin
      svc_mask[B_PURCHASE] = 1'b1;
      svc_code             = EV_PURCHASE;
      svc_push             = 1'b1;
    end else if (pend_q[B_QUARTER]) begin
      svc_mask[B_QUARTER] = 1'b1;
      svc_code            = EV_QUARTER;
      svc_push            = 1'b1;
    end else if (pend_q[B_DIME]) begin
      svc_mask[B_DIME] = 1'b1;
      svc_code         = EV_DIME;
      svc_push         = 1'b1;
    end else if (pend_q[B_NICKEL]) begin
      svc_mask[B_NICKEL] = 1'b1;
      svc_code           = EV_NICKEL;
      svc_push           = 1'b1;
    end
    // A clear discards everything else that was waiting; rises landing on
    // this same edge are kept since they happen after the clear.
    if (svc_clear) begin
      pend_d = rise;
    end else begin
      pend_d = (pend_q & ~svc_mask) | rise;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // ------------------------------------------------------------------
  // Event FIFO
  // ------------------------------------------------------------------
  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW-1:0] rd_nxt;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;
  ev_code_e      head_q, head_d;
  logic          full, pop, push, drop;
  logic          mem_we;
  logic [PW-1:0] mem_waddr;
  logic [2:0]    mem_wdata;

  assign rd_nxt = rd_q + 1'b1;

  always_comb begin
    full      = (count_q == CNT_FULL);
    pop       = valid_q & ack & ~svc_clear;
    push      = svc_push & (~full | pop);
    drop      = svc_push & full & ~pop;
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    head_d    = head_q;
    mem_we    = 1'b0;
    mem_waddr = wr_q;
    mem_wdata = svc_code;

    if (svc_clear) begin
      rd_d      = '0;
      wr_d      = (PW)'(1);
      count_d   = CNT_ONE;
      ovf_d     = 1'b0;
      head_d    = EV_CLEAR;
      mem_we    = 1'b1;
      mem_waddr = '0;
      mem_wdata = EV_CLEAR;
    end else begin
      mem_we = push;
      if (push) begin
        wr_d = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_nxt;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | drop;
      // The registered head is rebuilt from what the queue will hold after
      // this edge, so a push into an empty (or just-emptied) queue bypasses
      // the memory read.
      if (pop) begin
        if (count_q == CNT_ONE) begin
          head_d = push ? svc_code : EV_NONE;
        end else begin
          head_d = ev_code_e'(mem_q[rd_nxt]);
        end
      end else if (count_q == '0) begin
        head_d = push ? svc_code : EV_NONE;
      end
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      head_q  <= EV_NONE;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

  assign ev_valid   = valid_q;
  assign ev_code    = head_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_vend_event_arbiter.sv
// tb_vend_event_arbiter
//   Directed scenarios with literal expectations plus a randomized phase, all
//   compared every cycle against a queue-based behavioural model.
module tb_vend_event_arbiter;

  localparam int DB    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic       tick = 1'b0;
  logic       btn_clr = 1'b0, btn_purchase = 1'b0, btn_nickel = 1'b0;
  logic       btn_dime = 1'b0, btn_quarter = 1'b0;
  logic       ack = 1'b0;
  logic       ev_valid;
  logic [2:0] ev_code;
  logic [2:0] fifo_count;
  logic       overflow;

  always #5 clk = ~clk;

  vend_event_arbiter #(.DEBOUNCE_TICKS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .clr_n(clr_n), .tick(tick),
    .btn_clr(btn_clr), .btn_purchase(btn_purchase), .btn_nickel(btn_nickel),
    .btn_dime(btn_dime), .btn_quarter(btn_quarter), .ack(ack),
    .ev_valid(ev_valid), .ev_code(ev_code), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: button i (0 nickel .. 4 clear) produces code i+1.
  // ------------------------------------------------------------------
  bit m_s1 [5];
  bit m_s2 [5];
  bit m_deb [5];
  int m_run [5];
  bit m_pend [5];
  int m_q [$];
  bit m_ovf;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0; m_pend[i] = 0;
    end
    m_q.delete();
    m_ovf = 0;
  endtask

  task automatic model_step();
    bit btn [5];
    bit rise [5];
    int svc;
    bit popq;
    btn[0] = btn_nickel; btn[1] = btn_dime; btn[2] = btn_quarter;
    btn[3] = btn_purchase; btn[4] = btn_clr;
    for (int i = 0; i < 5; i++) begin
      rise[i] = 0;
      if (tick) begin
        if (m_s2[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_deb[i] = m_s2[i];
            m_run[i] = 0;
            rise[i]  = m_s2[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = btn[i];
    end
    svc = -1;
    for (int i = 4; i >= 0; i--) if (m_pend[i] && svc < 0) svc = i;
    popq = (m_q.size() != 0) && ack;
    if (svc == 4) begin
      m_q.delete();
      m_q.push_back(5);
      m_ovf = 0;
      for (int i = 0; i < 5; i++) m_pend[i] = rise[i];
    end else begin
      if (popq) void'(m_q.pop_front());
      if (svc >= 0) begin
        m_pend[svc] = 0;
        if (m_q.size() < DEPTH) m_q.push_back(svc + 1);
        else m_ovf = 1;
      end
      for (int i = 0; i < 5; i++) m_pend[i] = m_pend[i] | rise[i];
    end
  endtask

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) model_reset();
    else model_step();
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("m_valid", ev_valid, (m_q.size() != 0) ? 1 : 0);
    check("m_code", ev_code, (m_q.size() != 0) ? m_q[0] : 0);
    check("m_count", fifo_count, m_q.size());
    check("m_ovf", overflow, m_ovf);
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_pulse();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_pulse();
  endtask

  // Last debouncing tick: returns at the negedge just after the tick edge.
  task automatic last_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic ack_once();
    ack = 1'b1;
    @(negedge clk) ack = 1'b0;
  endtask

  initial begin
    #2 clr_n = 1'b0;
    clks(2);
    check("reset_valid", ev_valid, 0);
    check("reset_code", ev_code, 0);
    check("reset_count", fifo_count, 0);
    check("reset_ovf", overflow, 0);
    @(posedge clk); #3 clr_n = 1'b1;
    clks(2);

    // Short nickel glitch: three ticks only.
    btn_nickel = 1'b1; clks(3); ticks(3);
    btn_nickel = 1'b0; clks(3); ticks(4);
    check("glitch_count", fifo_count, 0);
    check("glitch_valid", ev_valid, 0);

    // Dime held for six ticks.
    btn_dime = 1'b1; clks(3); ticks(3);
    last_tick();
    check("dime_early_valid", ev_valid, 0);
    @(negedge clk);
    check("dime_valid", ev_valid, 1);
    check("dime_code", ev_code, 2);
    check("dime_count", fifo_count, 1);
    ticks(2);
    check("dime_once", fifo_count, 1);
    btn_dime = 1'b0; clks(3); ticks(5);
    ack_once();
    check("dime_popped", fifo_count, 0);

    // Four buttons at once: purchase, quarter, dime, nickel on consecutive clks.
    btn_purchase = 1'b1; btn_quarter = 1'b1; btn_dime = 1'b1; btn_nickel = 1'b1;
    clks(3); ticks(3);
    last_tick();
    check("multi_cnt0", fifo_count, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("multi_cnt", fifo_count, k);
      check("multi_head", ev_code, 4);
    end
    btn_purchase = 1'b0; btn_quarter = 1'b0; btn_dime = 1'b0; btn_nickel = 1'b0;
    clks(3); ticks(5);
    check("multi_hold", fifo_count, 4);

    // Nickel into a full queue without ack: dropped.
    btn_nickel = 1'b1; clks(3); ticks(3);
    last_tick(); @(negedge clk);
    check("drop_count", fifo_count, 4);
    check("drop_ovf", overflow, 1);
    check("drop_head", ev_code, 4);
    btn_nickel = 1'b0; clks(3); ticks(5);

    // Nickel into a full queue with ack on the service edge: push and pop.
    btn_nickel = 1'b1; clks(3); ticks(3);
    last_tick(); ack_once();
    check("pp_count", fifo_count, 4);
    check("pp_ovf", overflow, 1);
    check("pp_head", ev_code, 3);
    btn_nickel = 1'b0; clks(3); ticks(5);

    // Clear with three queued events, overflow set, ack on the service edge.
    ack_once();
    check("pre_clr_count", fifo_count, 3);
    check("pre_clr_ovf", overflow, 1);
    check("pre_clr_head", ev_code, 2);
    btn_clr = 1'b1; clks(3); ticks(3);
    last_tick(); ack_once();
    check("clr_count", fifo_count, 1);
    check("clr_code", ev_code, 5);
    check("clr_ovf", overflow, 0);
    btn_clr = 1'b0; clks(3); ticks(5);
    ack_once();
    check("clr_popped", fifo_count, 0);
    check("clr_popped_code", ev_code, 0);

    // Asynchronous reset mid-debounce with two queued entries.
    btn_nickel = 1'b1; btn_dime = 1'b1; clks(3); ticks(4); clks(3);
    check("rst_pre_count", fifo_count, 2);
    check("rst_pre_head", ev_code, 2);
    btn_nickel = 1'b0; btn_dime = 1'b0; btn_quarter = 1'b1;
    clks(3); ticks(2);
    @(posedge clk); #2 clr_n = 1'b0;
    #1;
    check("arst_valid", ev_valid, 0);
    check("arst_code", ev_code, 0);
    check("arst_count", fifo_count, 0);
    check("arst_ovf", overflow, 0);
    clks(3);
    @(posedge clk); #3 clr_n = 1'b1;
    clks(3); ticks(4); clks(2);
    check("post_rst_count", fifo_count, 1);
    check("post_rst_code", ev_code, 3);
    ticks(3);
    check("post_rst_once", fifo_count, 1);
    btn_quarter = 1'b0; clks(3); ticks(5);
    ack_once();

    // Randomized phase.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      tick = ($urandom_range(0, 2) == 0);
      if (cyc < 2000) ack = ($urandom_range(0, 7) == 0);
      else ack = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 29) == 0) btn_nickel = ~btn_nickel;
      if ($urandom_range(0, 29) == 0) btn_dime = ~btn_dime;
      if ($urandom_range(0, 29) == 0) btn_quarter = ~btn_quarter;
      if ($urandom_range(0, 39) == 0) btn_purchase = ~btn_purchase;
      if ($urandom_range(0, 299) == 0) btn_clr = ~btn_clr;
      if (cyc == 2500) begin
        #2 clr_n = 1'b0;
      end
      if (cyc == 2503) begin
        #3 clr_n = 1'b1;
      end
    end
    tick = 1'b0; ack = 1'b0;
    clks(2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
